// File: rtl/neg_line_encoder_2b.sv
// Active-low one-hot line encoder with stability qualification and valid/ready output.
// Optional ENC_MULTI_ERR_EN: multi-line faults pulse err instead of encoding by priority.
//
// state   | meaning
// IDLE    | waiting for en=1 and at least one asserted line
// QUAL    | counting consecutive identical samples of the candidate pattern
// HOLD    | code presented with valid=1 until the consumer takes it
// RELEASE | waiting for all lines to return high before re-arming
module neg_line_encoder_2b #(
   parameter int STABLE_CYCLES = 3,
   parameter int CNT_W         = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] y_n,
   output logic [1:0] code,
   output logic       valid,
   input  logic       ready,
   output logic       busy,
   output logic       err
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      QUAL    = 2'd1,
      HOLD    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       samp_q;
   logic [3:0]       samp_ref_q, samp_ref_d;
   logic [1:0]       cand_q, cand_d;
   logic [1:0]       code_q, code_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;

   logic [3:0]       act;
   logic             multi;
   logic             finish;
   logic [1:0]       fin_code;

   function automatic logic [1:0] prio(input logic [3:0] a);
      if (a[3])      return 2'd3;
      else if (a[2]) return 2'd2;
      else if (a[1]) return 2'd1;
      else           return 2'd0;
   endfunction

   assign act   = ~samp_q;
   assign multi = (act & (act - 4'd1)) != 4'd0;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      samp_ref_d = samp_ref_q;
      cand_d     = cand_q;
      code_d     = code_q;
      valid_d    = valid_q;
      err_d      = 1'b0;
      finish     = 1'b0;
      fin_code   = cand_q;

      case (state_q)
         IDLE: begin
            if (en && (act != 4'd0)) begin
               cand_d     = prio(act);
               samp_ref_d = samp_q;
               cnt_d      = CNT_W'(1);
               state_d    = QUAL;
               finish     = (STABLE_C == CNT_W'(1));
               fin_code   = prio(act);
            end
         end
         QUAL: begin
            if ((samp_q != samp_ref_q) || !en || (act == 4'd0)) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d  = cnt_q + CNT_W'(1);
               finish = ((cnt_q + CNT_W'(1)) == STABLE_C);
            end
         end
         HOLD: begin
            if (valid_q && ready) begin
               valid_d = 1'b0;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            if (samp_q == 4'b1111) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // The qualification point is shared by the IDLE entry (STABLE_CYCLES=1) and QUAL.
      if (finish) begin
`ifdef ENC_MULTI_ERR_EN
         if (multi) begin
            err_d   = 1'b1;
            state_d = RELEASE;
         end else begin
            code_d  = fin_code;
            valid_d = 1'b1;
            state_d = HOLD;
         end
`else
         code_d  = fin_code;
         valid_d = 1'b1;
         state_d = HOLD;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         samp_q     <= 4'b1111;
         samp_ref_q <= 4'b1111;
         cand_q     <= 2'b00;
         code_q     <= 2'b00;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         samp_q     <= y_n;
         samp_ref_q <= samp_ref_d;
         cand_q     <= cand_d;
         code_q     <= code_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
      end
   end

`ifndef ENC_MULTI_ERR_EN
   logic unused_multi;
   assign unused_multi = multi;
`endif

   assign code  = code_q;
   assign valid = valid_q;
   assign busy  = (state_q != IDLE);
`ifdef ENC_MULTI_ERR_EN
   assign err   = err_q;
`else
   assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_neg_line_encoder_2b.sv
// Directed bench for neg_line_encoder_2b with default parameters (STABLE_CYCLES=3).
module tb_neg_line_encoder_2b;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [3:0] y_n;
   logic [1:0] code;
   logic       valid;
   logic       ready;
   logic       busy;
   logic       err;

   int n_vec = 0;
   int n_err = 0;

   neg_line_encoder_2b dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .y_n   (y_n),
      .code  (code),
      .valid (valid),
      .ready (ready),
      .busy  (busy),
      .err   (err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic encode_ready(input logic [3:0] yv, input logic [1:0] exp_code);
      y_n = yv;
      step();  check("enc_e1_valid", {3'b0, valid}, 4'd0);
               check("enc_e1_busy",  {3'b0, busy},  4'd0);
      step();  check("enc_e2_busy",  {3'b0, busy},  4'd1);
               check("enc_e2_valid", {3'b0, valid}, 4'd0);
      step();  check("enc_e3_valid", {3'b0, valid}, 4'd0);
      step();  check("enc_e4_valid", {3'b0, valid}, 4'd1);
               check("enc_e4_code",  {2'b0, code},  {2'b0, exp_code});
               check("enc_e4_err",   {3'b0, err},   4'd0);
      step();  check("enc_e5_valid", {3'b0, valid}, 4'd0);
               check("enc_e5_busy",  {3'b0, busy},  4'd1);
               check("enc_e5_code",  {2'b0, code},  {2'b0, exp_code});
      y_n = 4'b1111;
      step();  check("enc_e6_busy",  {3'b0, busy},  4'd1);
      step();  check("enc_e7_busy",  {3'b0, busy},  4'd0);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; y_n = 4'b0000; ready = 1'b0;
      step(); step();
      check("rst_code",  {2'b0, code},  4'd0);
      check("rst_valid", {3'b0, valid}, 4'd0);
      check("rst_busy",  {3'b0, busy},  4'd0);
      check("rst_err",   {3'b0, err},   4'd0);

      rst = 1'b0; y_n = 4'b1111; en = 1'b1; ready = 1'b1;
      step(); step();
      check("post_rst_busy", {3'b0, busy}, 4'd0);

      // basic encode, ready held high
      encode_ready(4'b1011, 2'b10);
      encode_ready(4'b1110, 2'b00);
      encode_ready(4'b1101, 2'b01);
      encode_ready(4'b0111, 2'b11);

      // short glitch is rejected
      y_n = 4'b1110;
      step(); step();
      y_n = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         step(); check("glitch_valid", {3'b0, valid}, 4'd0);
      end
      check("glitch_busy", {3'b0, busy}, 4'd0);

      // pattern change mid-QUAL restarts qualification
      y_n = 4'b1110;
      step(); step();
      y_n = 4'b1101;
      step(); check("rst_q_e3_valid", {3'b0, valid}, 4'd0);
      step(); check("rst_q_e4_busy",  {3'b0, busy},  4'd0);
      step(); check("rst_q_e5_valid", {3'b0, valid}, 4'd0);
      step(); check("rst_q_e6_valid", {3'b0, valid}, 4'd0);
      step(); check("rst_q_e7_valid", {3'b0, valid}, 4'd1);
              check("rst_q_e7_code",  {2'b0, code},  4'd1);
      step(); check("rst_q_e8_valid", {3'b0, valid}, 4'd0);
      y_n = 4'b1111;
      step(); step(); step();
      check("rst_q_idle", {3'b0, busy}, 4'd0);

      // backpressure, en and y_n ignored in HOLD
      ready = 1'b0; y_n = 4'b0111;
      step(); step(); step(); step();
      check("bp_valid", {3'b0, valid}, 4'd1);
      check("bp_code",  {2'b0, code},  4'd3);
      for (int i = 0; i < 10; i++) begin
         y_n = (i % 2 == 0) ? 4'b1110 : 4'b1111;
         en  = (i < 5);
         step();
         check("bp_hold_valid", {3'b0, valid}, 4'd1);
         check("bp_hold_code",  {2'b0, code},  4'd3);
      end
      y_n = 4'b0111;
      step();
      ready = 1'b1;
      step(); check("bp_xfer_valid", {3'b0, valid}, 4'd0);
      en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         check("rel_valid", {3'b0, valid}, 4'd0);
         check("rel_busy",  {3'b0, busy},  4'd1);
      end
      y_n = 4'b1111;
      step(); check("rel_e1_busy", {3'b0, busy}, 4'd1);
      step(); check("rel_e2_busy", {3'b0, busy}, 4'd0);

      // enable gating
      en = 1'b0; y_n = 4'b1110;
      for (int i = 0; i < 20; i++) begin
         step();
         check("en0_valid", {3'b0, valid}, 4'd0);
         check("en0_busy",  {3'b0, busy},  4'd0);
      end
      en = 1'b1;
      step(); check("en_qual_busy", {3'b0, busy}, 4'd1);
      en = 1'b0;
      step(); check("en_abort_busy",  {3'b0, busy},  4'd0);
              check("en_abort_valid", {3'b0, valid}, 4'd0);
      y_n = 4'b1111; en = 1'b1;
      step(); step();

      // multi-line input
      y_n = 4'b0110;
      step(); step(); step(); step();
`ifdef ENC_MULTI_ERR_EN
      check("multi_err",   {3'b0, err},   4'd1);
      check("multi_valid", {3'b0, valid}, 4'd0);
      check("multi_busy",  {3'b0, busy},  4'd1);
      step();
      check("multi_err_pulse", {3'b0, err},   4'd0);
      check("multi_no_valid",  {3'b0, valid}, 4'd0);
`else
      check("multi_valid", {3'b0, valid}, 4'd1);
      check("multi_code",  {2'b0, code},  4'd3);
      check("multi_err",   {3'b0, err},   4'd0);
      step();
      check("multi_xfer", {3'b0, valid}, 4'd0);
`endif
      y_n = 4'b1111;
      step(); step();
      check("multi_idle", {3'b0, busy}, 4'd0);

      // reset overrides a pending handshake
      ready = 1'b0; y_n = 4'b1011;
      step(); step(); step(); step();
      check("pre_rst_valid", {3'b0, valid}, 4'd1);
      rst = 1'b1;
      step();
      check("rst_hold_valid", {3'b0, valid}, 4'd0);
      check("rst_hold_busy",  {3'b0, busy},  4'd0);
      check("rst_hold_code",  {2'b0, code},  4'd0);
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
